// File: rtl/seq_player.sv
// Step-sequence store and player: appends 2-bit steps in write order and replays
// them with HOLD cycles of presentation per step and GAP blank cycles in between.
module seq_player #(
  parameter int DEPTH = 8,
  parameter int HOLD  = 4,
  parameter int GAP   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [1:0]                 wr_data,
  input  logic                       clr,
  input  logic                       start,
  output logic                       busy,
  output logic                       step_valid,
  output logic [1:0]                 step_data,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic [$clog2(DEPTH):0]     len,
  output logic                       full,
  output logic                       done,
  output logic [1:0]                 dbg_state
);

  localparam int IW   = $clog2(DEPTH);
  localparam int LW   = IW + 1;
  localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [LW-1:0]  len_q, len_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;
  logic [1:0]     data_q, data_d;
  logic           full_q, full_d;
  logic           done_q, done_d;

  logic [1:0]     mem_q [DEPTH];
  logic           mem_we;
  logic           last_step;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    last_step = ({1'b0, idx_q} == (len_q - LW'(1)));

    if (wr_en && !clr && (len_q != LW'(DEPTH)) &&
        (state_q == S_IDLE || state_q == S_DONE)) begin
      mem_we = 1'b1;
      len_d  = len_q + LW'(1);
    end

    case (state_q)
      S_IDLE: begin
        // len_d already includes a write accepted in this same cycle
        if (start && !clr) begin
          if (len_d != '0) begin
            state_d = S_SHOW;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SHOW: begin
        if (int'(cnt_q) == HOLD - 1) begin
          cnt_d = '0;
          if (last_step) begin
            state_d = S_DONE;
          end else if (GAP > 0) begin
            state_d = S_GAP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (int'(cnt_q) == GAP - 1) begin
          cnt_d   = '0;
          state_d = S_SHOW;
          idx_d   = idx_q + IW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (clr) begin
      state_d = S_IDLE;
      len_d   = '0;
      cnt_d   = '0;
    end

    if (state_d == S_IDLE || state_d == S_DONE) begin
      idx_d = '0;
    end

    busy_d  = (state_d == S_SHOW) || (state_d == S_GAP);
    valid_d = (state_d == S_SHOW);
    full_d  = (len_d == LW'(DEPTH));
    done_d  = (state_d == S_DONE);
    data_d  = 2'b00;
    // A step written in the start cycle is not in mem_q yet, so forward it
    if (valid_d) begin
      if (mem_we && (len_q[IW-1:0] == idx_d)) begin
        data_d = wr_data;
      end else begin
        data_d = mem_q[idx_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 2'b00;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      full_q  <= full_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[len_q[IW-1:0]] <= wr_data;
    end
  end

  assign busy       = busy_q;
  assign step_valid = valid_q;
  assign step_data  = data_q;
  assign step_idx   = idx_q;
  assign len        = len_q;
  assign full       = full_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player: unit A uses HOLD=4/GAP=2, unit B uses HOLD=4/GAP=0;
// a monitor pops expected steps, run lengths and done markers from queues.
module tb_seq_player;

  localparam int DEPTH = 8;
  localparam int HOLD  = 4;
  localparam int GAP_A = 2;

  logic       clk = 1'b0;
  logic       rst, wr_en, clr, start, sel, mon_en;
  logic [1:0] wr_data;

  logic       a_busy, a_valid, a_full, a_done, b_busy, b_valid, b_full, b_done;
  logic [1:0] a_data, a_dbg, b_data, b_dbg;
  logic [2:0] a_idx, b_idx;
  logic [3:0] a_len, b_len;

  logic       m_busy, m_valid, m_done, o_act;
  logic [1:0] m_data;
  logic [2:0] m_idx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] exp_q[$];
  int         exp_run_q[$];
  int         exp_busy_q[$];
  logic       exp_done_q[$];

  logic [1:0] mdl [DEPTH];
  int         mdl_len = 0;
  logic [1:0] fill_d [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2};

  always #5 clk = ~clk;

  seq_player #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(GAP_A)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en & ~sel), .wr_data(wr_data),
    .clr(clr & ~sel), .start(start & ~sel), .busy(a_busy), .step_valid(a_valid),
    .step_data(a_data), .step_idx(a_idx), .len(a_len), .full(a_full),
    .done(a_done), .dbg_state(a_dbg)
  );

  seq_player #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(0)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en & sel), .wr_data(wr_data),
    .clr(clr & sel), .start(start & sel), .busy(b_busy), .step_valid(b_valid),
    .step_data(b_data), .step_idx(b_idx), .len(b_len), .full(b_full),
    .done(b_done), .dbg_state(b_dbg)
  );

  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_done  = sel ? b_done  : a_done;
  assign m_data  = sel ? b_data  : a_data;
  assign m_idx   = sel ? b_idx   : a_idx;
  assign o_act   = sel ? (a_busy | a_valid | a_done) : (b_busy | b_valid | b_done);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: valid/ready here is step_valid (data), busy/step_valid falling (runs), done
  logic prev_valid = 1'b0;
  logic prev_busy  = 1'b0;
  int   vrun = 0;
  int   brun = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_valid) begin
        if (exp_q.size() == 0) check("step_unexpected", m_valid, 0);
        else check("step", {m_idx, m_data}, exp_q.pop_front());
        vrun++;
      end else if (prev_valid) begin
        if (exp_run_q.size() == 0) check("run_unexpected", vrun, 0);
        else check("run_len", vrun, exp_run_q.pop_front());
        vrun = 0;
      end
      if (m_busy) begin
        brun++;
      end else if (prev_busy) begin
        if (exp_busy_q.size() == 0) check("busy_unexpected", brun, 0);
        else check("busy_len", brun, exp_busy_q.pop_front());
        brun = 0;
      end
      if (m_done) begin
        if (exp_done_q.size() == 0) check("done_unexpected", m_done, 0);
        else check("done_after_show", prev_valid, exp_done_q.pop_front());
        check("busy_at_done", m_busy, 0);
      end
      check("blank_outputs", {(m_valid ? 2'b00 : m_data), (m_busy ? 3'b000 : m_idx)}, 0);
      check("other_quiet", o_act, 0);
      prev_valid = m_valid;
      prev_busy  = m_busy;
    end
  end

  // Drive one cycle of inputs; returns 1 time unit after the sampling edge
  task automatic cycle_in(input logic w, input logic [1:0] d, input logic c, input logic s);
    wr_en = w; wr_data = d; clr = c; start = s;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_data = 2'b00; clr = 1'b0; start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [1:0] d);
    cycle_in(1'b1, d, 1'b0, 1'b0);
    if (mdl_len < DEPTH) begin
      mdl[mdl_len] = d;
      mdl_len++;
    end
  endtask

  task automatic push_play(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int h = 0; h < HOLD; h++) exp_q.push_back({3'(i), mdl[i]});
      if (gap > 0) exp_run_q.push_back(HOLD);
    end
    if (gap == 0) exp_run_q.push_back(n * HOLD);
    exp_busy_q.push_back(n * HOLD + (n - 1) * gap);
    exp_done_q.push_back(1'b1);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (m_busy && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    check("idle_timeout", m_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mon_en = 1'b0;
    sel = 1'b0; rst = 1'b1; wr_en = 1'b1; start = 1'b1; clr = 1'b0; wr_data = 2'd3;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0; start = 1'b0; wr_data = 2'd0;
    check("rst_busy", a_busy, 0);
    check("rst_valid", a_valid, 0);
    check("rst_data", a_data, 0);
    check("rst_idx", a_idx, 0);
    check("rst_len", a_len, 0);
    check("rst_full", a_full, 0);
    check("rst_done", a_done, 0);
    check("rst_len_b", b_len, 0);
    mon_en = 1'b1;

    // Basic three-step playback
    wr(2'd3); wr(2'd1); wr(2'd2);
    check("len_3", a_len, 3);
    push_play(3, GAP_A);
    cycle_in(1'b0, 2'd0, 1'b0, 1'b1);
    check("start_latency", {a_busy, a_valid, a_idx, a_data}, {1'b1, 1'b1, 3'd0, 2'd3});
    wait_idle();
    idle(1);
    check("done_one_cycle", a_done, 0);
    idle(1);

    // Fill to DEPTH, ninth write dropped
    cycle_in(1'b0, 2'd0, 1'b1, 1'b0);
    mdl_len = 0;
    for (int i = 0; i < 9; i++) begin
      wr(fill_d[i]);
      if (i == 7) check("fill_8", {a_full, a_len}, {1'b1, 4'd8});
    end
    check("fill_9", {a_full, a_len}, {1'b1, 4'd8});
    push_play(8, GAP_A);
    cycle_in(1'b0, 2'd0, 1'b0, 1'b1);
    wait_idle();
    idle(2);

    // Empty start: done only
    cycle_in(1'b0, 2'd0, 1'b1, 1'b0);
    mdl_len = 0;
    check("clr_full", {a_full, a_len}, 0);
    exp_done_q.push_back(1'b0);
    cycle_in(1'b0, 2'd0, 1'b0, 1'b1);
    check("empty_done", {a_done, a_busy, a_valid}, 3'b100);
    idle(1);
    check("empty_done_once", a_done, 0);

    // Writes and restart attempts during playback are ignored
    wr(2'd1); wr(2'd2);
    push_play(2, GAP_A);
    cycle_in(1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle_in(1'b1, 2'd3, 1'b0, 1'b0);
    cycle_in(1'b0, 2'd0, 1'b0, 1'b1);
    wait_idle();
    idle(2);
    check("len_busy_write", a_len, 2);

    // clr during first gap aborts
    cycle_in(1'b0, 2'd0, 1'b1, 1'b0);
    mdl_len = 0;
    wr(2'd0); wr(2'd1); wr(2'd3);
    for (int h = 0; h < HOLD; h++) exp_q.push_back({3'd0, 2'd0});
    exp_run_q.push_back(HOLD);
    exp_busy_q.push_back(HOLD + 1);
    cycle_in(1'b0, 2'd0, 1'b0, 1'b1);
    idle(HOLD);
    check("in_gap", {a_busy, a_valid, a_dbg}, {1'b1, 1'b0, 2'd2});
    cycle_in(1'b0, 2'd0, 1'b1, 1'b0);
    check("clr_abort", {a_busy, a_valid, a_done, a_len, a_dbg}, 0);
    idle(3);

    // rst mid-SHOW aborts
    mdl_len = 0;
    wr(2'd2); wr(2'd3);
    for (int h = 0; h < 3; h++) exp_q.push_back({3'd0, 2'd2});
    exp_run_q.push_back(3);
    exp_busy_q.push_back(3);
    cycle_in(1'b0, 2'd0, 1'b0, 1'b1);
    idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_len = 0;
    check("rst_abort", {a_busy, a_valid, a_data, a_idx, a_len, a_full, a_done}, 0);
    idle(3);

    // GAP=0 unit: continuous presentation
    sel = 1'b1;
    idle(1);
    wr(2'd0); wr(2'd3);
    check("b_len_2", b_len, 2);
    push_play(2, 0);
    cycle_in(1'b0, 2'd0, 1'b0, 1'b1);
    idle(HOLD - 1);
    check("b_last_first", {b_valid, b_data}, {1'b1, 2'd0});
    idle(1);
    check("b_switch", {b_valid, b_idx, b_data}, {1'b1, 3'd1, 2'd3});
    wait_idle();
    idle(2);

    // Write and start in the same cycle from len=1
    cycle_in(1'b0, 2'd0, 1'b1, 1'b0);
    mdl_len = 0;
    wr(2'd1);
    mdl[1] = 2'd2;
    mdl_len = 2;
    push_play(2, 0);
    cycle_in(1'b1, 2'd2, 1'b0, 1'b1);
    check("b_wr_start", {b_valid, b_data, b_len}, {1'b1, 2'd1, 4'd2});
    wait_idle();
    idle(2);
    check("b_len_after", b_len, 2);

    check("exp_q_empty", exp_q.size(), 0);
    check("run_q_empty", exp_run_q.size(), 0);
    check("busy_q_empty", exp_busy_q.size(), 0);
    check("done_q_empty", exp_done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
